alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter_pkg.sv | 26 ++
 rtl/alu_core.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter.
//   - ALU operand/result widths
//   - 3-bit opcode constants OP_ADD..OP_DIV
//   - arbiter FSM state encoding (IDLE/EXEC/RESP)
package alu_share_arbiter_pkg;

    localparam int unsigned ALU_OPND_W = 4;
    localparam int unsigned ALU_RES_W  = 8;
    localparam int unsigned ALU_OP_W   = 3;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_INV = 3'b101;
    localparam logic [ALU_OP_W-1:0] OP_MUL = 3'b110;
    localparam logic [ALU_OP_W-1:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit ALU with an 8-bit result.
// Ports:
//   a, b      in   4-bit operands
//   op        in   3-bit opcode (see alu_share_arbiter_pkg)
//   result    out  8-bit result
//   div_zero  out  divide by zero flag (only when ALU_DIVZ_ERR_EN is defined)
// Optional feature macro: ALU_DIVZ_ERR_EN
module alu_core
    import alu_share_arbiter_pkg::*;
(
    input  logic [ALU_OPND_W-1:0] a,
    input  logic [ALU_OPND_W-1:0] b,
    input  logic [ALU_OP_W-1:0]   op,
    output logic [ALU_RES_W-1:0]  result
`ifdef ALU_DIVZ_ERR_EN
    ,
    output logic                  div_zero
`endif
);

    always_comb begin
        result = '0;
`ifdef ALU_DIVZ_ERR_EN
        div_zero = 1'b0;
`endif
        case (op)
            OP_ADD: result = ALU_RES_W'(a) + ALU_RES_W'(b);
            OP_SUB: result = ALU_RES_W'(a) - ALU_RES_W'(b);
            OP_AND: result = ALU_RES_W'(a & b);
            OP_OR:  result = ALU_RES_W'(a | b);
            OP_XOR: result = ALU_RES_W'(a ^ b);
            OP_INV: result = {~b, ~a};
            OP_MUL: result = ALU_RES_W'(a) * ALU_RES_W'(b);
            OP_DIV: begin
                // Divide by zero yields 0x00 rather than an undefined quotient.
                if (b == '0) begin
`ifdef ALU_DIVZ_ERR_EN
                    div_zero = 1'b1;
`endif
                end else begin
                    result = ALU_RES_W'(a / b);
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with a
// round-robin grant. A granted request has its operands latched, runs
// through the ALU for one cycle, and the result is returned tagged with
// the requester index on a valid/ready response port.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NUM_REQ]    request pending per requester
//   req_ready  out  [NUM_REQ]    one-hot accept strobe (IDLE only)
//   req_a      in   [4*NUM_REQ]  operand a, requester i at [4i+3:4i]
//   req_b      in   [4*NUM_REQ]  operand b, same packing
//   req_op     in   [3*NUM_REQ]  opcode, requester i at [3i+2:3i]
//   rsp_valid  out  result available
//   rsp_ready  in   consumer accepts result
//   rsp_id     out  [ID_W] owner of the result
//   rsp_data   out  [8] ALU result
//   busy       out  high whenever not IDLE
//   rsp_err    out  divide-by-zero flag (only with ALU_DIVZ_ERR_EN)
// Optional feature macro: ALU_DIVZ_ERR_EN
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [ALU_OPND_W*NUM_REQ-1:0]  req_a,
    input  logic [ALU_OPND_W*NUM_REQ-1:0]  req_b,
    input  logic [ALU_OP_W*NUM_REQ-1:0]    req_op,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [ALU_RES_W-1:0]           rsp_data,
    output logic                           busy
`ifdef ALU_DIVZ_ERR_EN
    ,
    output logic                           rsp_err
`endif
);

    state_t                  state;
    state_t                  state_nxt;
    logic [ID_W-1:0]         rr_ptr;
    logic [ALU_OPND_W-1:0]   lat_a;
    logic [ALU_OPND_W-1:0]   lat_b;
    logic [ALU_OP_W-1:0]     lat_op;
    logic [ID_W-1:0]         lat_id;

    logic                    grant_found;
    logic [ID_W-1:0]         grant_idx;
    logic [NUM_REQ-1:0]      grant_onehot;
    logic [ALU_OPND_W-1:0]   sel_a;
    logic [ALU_OPND_W-1:0]   sel_b;
    logic [ALU_OP_W-1:0]     sel_op;
    int unsigned             scan;

    logic [ALU_RES_W-1:0]    alu_result;
`ifdef ALU_DIVZ_ERR_EN
    logic                    alu_div_zero;
`endif

    // Round-robin search: offset i from rr_ptr maps to requester scan,
    // wrapping once. The inner loop keeps every select index constant.
    always_comb begin
        grant_found  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        sel_a        = '0;
        sel_b        = '0;
        sel_op       = '0;
        scan         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan = 32'(rr_ptr) + i;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!grant_found && (j == scan) && req_valid[j]) begin
                    grant_found     = 1'b1;
                    grant_idx       = ID_W'(j);
                    grant_onehot[j] = 1'b1;
                    sel_a           = req_a[ALU_OPND_W*j +: ALU_OPND_W];
                    sel_b           = req_b[ALU_OPND_W*j +: ALU_OPND_W];
                    sel_op          = req_op[ALU_OP_W*j +: ALU_OP_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_found) begin
                    // Reset forces IDLE asynchronously; keep the strobe low
                    // while rst is held so no accept is advertised.
                    req_ready = rst ? '0 : grant_onehot;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    alu_core u_alu_core (
        .a        (lat_a),
        .b        (lat_b),
        .op       (lat_op),
        .result   (alu_result)
`ifdef ALU_DIVZ_ERR_EN
        ,
        .div_zero (alu_div_zero)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_op    <= '0;
            lat_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef ALU_DIVZ_ERR_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        lat_a  <= sel_a;
                        lat_b  <= sel_b;
                        lat_op <= sel_op;
                        lat_id <= grant_idx;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_valid <= 1'b1;
`ifdef ALU_DIVZ_ERR_EN
                    rsp_err   <= alu_div_zero;
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (lat_id == ID_W'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The latched id is held from accept until the next accept, so it is
    // stable for the whole response phase.
    assign rsp_id = lat_id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (NUM_REQ=2, ID_W=2).
// Reference: per-round service order from round-robin rules, results from
// arithmetic on the opcode table, cycle expectations from the grant /
// execute / respond timing.
module tb_alu_share_arbiter;

    localparam int NREQ = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [5:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        busy;
`ifdef ALU_DIVZ_ERR_EN
    logic        rsp_err;
`endif

    int total = 0;
    int bad   = 0;
    int mdl_ptr = 0;

    logic [3:0] ra [NREQ];
    logic [3:0] rb [NREQ];
    logic [2:0] rop [NREQ];

    alu_share_arbiter #(
        .NUM_REQ (2),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef ALU_DIVZ_ERR_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_alu(input int a, input int b, input int op);
        case (op)
            0: return a + b;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (15 - b) * 16 + (15 - a);
            6: return a * b;
            default: return (b == 0) ? 0 : a / b;
        endcase
    endfunction

    function automatic int ref_err(input int b, input int op);
        return (op == 7 && b == 0) ? 1 : 0;
    endfunction

    task automatic apply_operands();
        req_a  = {ra[1], ra[0]};
        req_b  = {rb[1], rb[0]};
        req_op = {rop[1], rop[0]};
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_data",  32'(rsp_data), 0);
        check_eq("rst_rsp_id",    32'(rsp_id), 0);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_busy",      32'(busy), 0);
        check_eq("rst_rr_ptr",    32'(dut.rr_ptr), 0);
`ifdef ALU_DIVZ_ERR_EN
        check_eq("rst_rsp_err",   32'(rsp_err), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mdl_ptr = 0;
    endtask

    // Requesters in vmask present ra/rb/rop and hold until accepted.
    // Called at posedge+1; returns at posedge+1 after the last handshake.
    task automatic run_round(input logic [1:0] vmask, input int min_stall);
        int         exp_id[$];
        logic [1:0] pend;
        logic [1:0] drop;
        int         p, c, t_free, t_rsp, waited, cur, exp_d;
        bit         in_flight;

        pend = vmask;
        p    = mdl_ptr;
        while (pend != 2'b00) begin
            if (pend[p]) begin
                exp_id.push_back(p);
                pend[p] = 1'b0;
            end
            p = (p + 1) % NREQ;
        end
        mdl_ptr = (exp_id[$] + 1) % NREQ;

        apply_operands();
        req_valid = vmask;
        c = 0; t_free = 0; t_rsp = 0; waited = 0; cur = 0; in_flight = 0;

        while (exp_id.size() > 0 && c < 400) begin
            @(negedge clk);
            drop = '0;
            if (!in_flight && c >= t_free) begin
                check_eq("idle_busy", 32'(busy), 0);
                check_eq("grant", 32'(req_ready), 32'(1 << exp_id[0]));
                check_eq("idle_rsp_valid", 32'(rsp_valid), 0);
                cur       = exp_id[0];
                drop[cur] = 1'b1;
                in_flight = 1;
                t_rsp     = c + 2;
                waited    = 0;
                rsp_ready = 1'($urandom_range(0, 1));
            end else if (c < t_rsp) begin
                check_eq("exec_rsp_valid", 32'(rsp_valid), 0);
                check_eq("exec_busy", 32'(busy), 1);
                check_eq("exec_req_ready", 32'(req_ready), 0);
                rsp_ready = 1'($urandom_range(0, 1));
            end else begin
                exp_d = ref_alu(int'(ra[cur]), int'(rb[cur]), int'(rop[cur]));
                check_eq("rsp_valid", 32'(rsp_valid), 1);
                check_eq("rsp_id", 32'(rsp_id), 32'(cur));
                check_eq("rsp_data", 32'(rsp_data), 32'(exp_d));
                check_eq("resp_busy", 32'(busy), 1);
                check_eq("resp_req_ready", 32'(req_ready), 0);
`ifdef ALU_DIVZ_ERR_EN
                check_eq("rsp_err", 32'(rsp_err),
                         32'(ref_err(int'(rb[cur]), int'(rop[cur]))));
`endif
                if (waited < min_stall)
                    rsp_ready = 1'b0;
                else if (waited >= min_stall + 3)
                    rsp_ready = 1'b1;
                else
                    rsp_ready = 1'($urandom_range(0, 1));
                waited++;
                if (rsp_ready) begin
                    void'(exp_id.pop_front());
                    in_flight = 0;
                    t_free    = c + 1;
                end
            end
            c++;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~drop;
        end
        if (c >= 400)
            check_eq("round_timeout", 32'(exp_id.size()), 0);
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0; rb[i] = '0; rop[i] = '0;
        end

        do_reset();

        // Single requester 0: 7 + 9
        ra[0] = 4'd7; rb[0] = 4'd9; rop[0] = 3'b000;
        run_round(2'b01, 0);

        // Both pending from reset: sub for 0, invert-concat for 1
        do_reset();
        ra[0] = 4'd3; rb[0] = 4'd5; rop[0] = 3'b001;
        ra[1] = 4'd3; rb[1] = 4'd5; rop[1] = 3'b101;
        run_round(2'b11, 0);

        // Rotation: after serving 0 alone, requester 1 goes first
        run_round(2'b01, 0);
        run_round(2'b11, 0);

        // Backpressure: 15*15 held for at least 5 cycles
        ra[1] = 4'd15; rb[1] = 4'd15; rop[1] = 3'b110;
        run_round(2'b10, 5);

        // Divide by zero, then a normal divide
        ra[0] = 4'd9; rb[0] = 4'd0; rop[0] = 3'b111;
        run_round(2'b01, 0);
        ra[0] = 4'd9; rb[0] = 4'd2; rop[0] = 3'b111;
        run_round(2'b01, 0);

        // Reset while a response is pending (rr_ptr is 1 here)
        ra[0] = 4'd4; rb[0] = 4'd4; rop[0] = 3'b000;
        apply_operands();
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
        check_eq("pre_rst_rsp_valid", 32'(rsp_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_rr_ptr", 32'(dut.rr_ptr), 0);
        check_eq("midrst_req_ready", 32'(req_ready), 0);
        check_eq("midrst_rsp_data", 32'(rsp_data), 0);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        mdl_ptr = 0;
        @(posedge clk);
        #1;

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                ra[i]  = 4'($urandom);
                rb[i]  = 4'($urandom);
                rop[i] = 3'($urandom);
            end
            run_round(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
